// File: rtl/galaga_pkg.sv
// Shared definitions for the Galaga ROM loader: image region map,
// region index enumeration and loader FSM states.
package galaga_pkg;

    localparam int ADDR_W   = 25;
    localparam int DN_W     = 17;
    localparam int NUM_RGN  = 6;

    localparam logic [16:0] CPU1_BASE   = 17'h00000;
    localparam logic [16:0] CPU1_LIMIT  = 17'h03FFF;
    localparam logic [16:0] CPU2_BASE   = 17'h04000;
    localparam logic [16:0] CPU2_LIMIT  = 17'h04FFF;
    localparam logic [16:0] CPU3_BASE   = 17'h05000;
    localparam logic [16:0] CPU3_LIMIT  = 17'h05FFF;
    localparam logic [16:0] TILE_BASE   = 17'h06000;
    localparam logic [16:0] TILE_LIMIT  = 17'h06FFF;
    localparam logic [16:0] SPR_BASE    = 17'h07000;
    localparam logic [16:0] SPR_LIMIT   = 17'h08FFF;
    localparam logic [16:0] PROM_BASE   = 17'h09000;
    localparam logic [16:0] PROM_LIMIT  = 17'h093FF;

    typedef enum logic [2:0] {
        RGN_CPU1 = 3'd0,
        RGN_CPU2 = 3'd1,
        RGN_CPU3 = 3'd2,
        RGN_TILE = 3'd3,
        RGN_SPR  = 3'd4,
        RGN_PROM = 3'd5
    } rgn_idx_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_HOLD = 3'd2,
        ST_RUN  = 3'd3,
        ST_ERR  = 3'd4
    } load_state_e;

    function automatic logic in_window(input logic [16:0] a,
                                       input logic [16:0] base,
                                       input logic [16:0] limit);
        return (a >= base) && (a <= limit);
    endfunction

endpackage

// File: rtl/rom_region_decode.sv
// Combinational decode of a download byte address into a one-hot ROM region
// select; in_range is high only for addresses inside the image.
module rom_region_decode
    import galaga_pkg::*;
(
    input  logic [24:0] addr,
    output logic [5:0]  rgn_sel,
    output logic        in_range
);

    logic [16:0] low_s;
    logic        high_clear_s;

    assign low_s        = addr[16:0];
    assign high_clear_s = (addr[24:17] == 8'h00);

    // Region windows are contiguous, so any hit means the byte lies in the image
    always_comb begin
        rgn_sel = 6'b000000;
        if (high_clear_s) begin
            rgn_sel[RGN_CPU1] = in_window(low_s, CPU1_BASE, CPU1_LIMIT);
            rgn_sel[RGN_CPU2] = in_window(low_s, CPU2_BASE, CPU2_LIMIT);
            rgn_sel[RGN_CPU3] = in_window(low_s, CPU3_BASE, CPU3_LIMIT);
            rgn_sel[RGN_TILE] = in_window(low_s, TILE_BASE, TILE_LIMIT);
            rgn_sel[RGN_SPR]  = in_window(low_s, SPR_BASE,  SPR_LIMIT);
            rgn_sel[RGN_PROM] = in_window(low_s, PROM_BASE, PROM_LIMIT);
        end else begin
            rgn_sel = 6'b000000;
        end
    end

    assign in_range = |rgn_sel;

endmodule

// File: rtl/rom_loader.sv
// HPS ROM download receiver: forwards image bytes to the core ROMs, checks the
// image size and holds the game core in reset until a valid image is present.
module rom_loader
    import galaga_pkg::*;
#(
    parameter int LOAD_BYTES  = 37888,
    parameter int HOLD_CYCLES = 16
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [16:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic [5:0]  rgn_sel,
    output logic        core_reset,
    output logic        load_done,
    output logic        load_err,
    output logic [15:0] checksum,
    output logic [16:0] byte_count
);

    load_state_e state_r;
    load_state_e state_next_s;

    logic        dl_q_r;
    logic        wr_q_r;
    logic        ovf_r;
    logic [15:0] hold_cnt_r;

    logic [5:0]  dec_sel_s;
    logic        dec_in_range_s;
    logic        dl_rise_s;
    logic        dl_fall_s;
    logic        wr_event_s;
    logic        accept_s;
    logic        reject_s;
    logic        load_entry_s;
    logic [16:0] count_next_s;
    logic [15:0] sum_next_s;
    logic        ovf_next_s;

    rom_region_decode u_decode (
        .addr     (ioctl_addr),
        .rgn_sel  (dec_sel_s),
        .in_range (dec_in_range_s)
    );

    assign dl_rise_s  = ioctl_download & ~dl_q_r;
    assign dl_fall_s  = ~ioctl_download & dl_q_r;
    // A strobe rising in the very cycle the download drops still belongs to the session
    assign wr_event_s = ioctl_wr & ~wr_q_r & (ioctl_download | dl_q_r);
    assign accept_s   = (state_r == ST_LOAD) & wr_event_s & dec_in_range_s;
    assign reject_s   = (state_r == ST_LOAD) & wr_event_s & ~dec_in_range_s;

    // Running count/sum/overflow including this cycle's event, used by the exit decision
    always_comb begin
        count_next_s = byte_count;
        sum_next_s   = checksum;
        ovf_next_s   = ovf_r;
        if (accept_s) begin
            count_next_s = (byte_count == 17'h1FFFF) ? byte_count : byte_count + 17'd1;
            sum_next_s   = checksum + {8'h00, ioctl_dout};
        end else if (reject_s) begin
            ovf_next_s = 1'b1;
        end else begin
            ovf_next_s = ovf_r;
        end
    end

    // Loader FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (dl_rise_s) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_LOAD: begin
                if (!dl_fall_s) begin
                    state_next_s = ST_LOAD;
                end else if ((count_next_s == 17'(LOAD_BYTES)) && !ovf_next_s) begin
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_ERR;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_r == 16'(HOLD_CYCLES - 1)) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    assign load_entry_s = (state_next_s == ST_LOAD) && (state_r != ST_LOAD);

    // FSM state register
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Edge detectors, core write port, load statistics and status outputs
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            dl_q_r     <= 1'b0;
            wr_q_r     <= 1'b0;
            ovf_r      <= 1'b0;
            hold_cnt_r <= 16'd0;
            dn_wr      <= 1'b0;
            dn_addr    <= 17'd0;
            dn_data    <= 8'd0;
            rgn_sel    <= 6'b000000;
            byte_count <= 17'd0;
            checksum   <= 16'd0;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            dl_q_r  <= ioctl_download;
            wr_q_r  <= ioctl_wr;
            dn_wr   <= accept_s;
            rgn_sel <= accept_s ? dec_sel_s : 6'b000000;
            if (accept_s) begin
                dn_addr <= ioctl_addr[16:0];
                dn_data <= ioctl_dout;
            end
            if (load_entry_s) begin
                byte_count <= 17'd0;
                checksum   <= 16'd0;
                ovf_r      <= 1'b0;
            end else begin
                byte_count <= count_next_s;
                checksum   <= sum_next_s;
                ovf_r      <= ovf_next_s;
            end
            hold_cnt_r <= (state_r == ST_HOLD) ? hold_cnt_r + 16'd1 : 16'd0;
            core_reset <= (state_next_s != ST_RUN);
            load_done  <= (state_next_s == ST_RUN);
            load_err   <= (state_next_s == ST_ERR);
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Randomized self-checking bench for rom_loader against a behavioural model of
// the download rules (region map, byte count, checksum, hold timing).
module tb_rom_loader;

    localparam int N    = 96;
    localparam int HOLD = 16;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [16:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic [5:0]  rgn_sel;
    logic        core_reset;
    logic        load_done;
    logic        load_err;
    logic [15:0] checksum;
    logic [16:0] byte_count;

    always #5 clk_sys = ~clk_sys;

    rom_loader #(.LOAD_BYTES(N), .HOLD_CYCLES(HOLD)) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_wr          (dn_wr),
        .rgn_sel        (rgn_sel),
        .core_reset     (core_reset),
        .load_done      (load_done),
        .load_err       (load_err),
        .checksum       (checksum),
        .byte_count     (byte_count)
    );

    int checks   = 0;
    int failures = 0;
    int model_count;
    int model_sum;
    bit model_ovf;
    bit model_loading;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic logic [5:0] ref_region(input logic [24:0] a);
        int v;
        v = int'(a);
        if (v < 'h04000)      return 6'b000001;
        else if (v < 'h05000) return 6'b000010;
        else if (v < 'h06000) return 6'b000100;
        else if (v < 'h07000) return 6'b001000;
        else if (v < 'h09000) return 6'b010000;
        else if (v < 'h09400) return 6'b100000;
        else                  return 6'b000000;
    endfunction

    function automatic logic [24:0] rand_addr();
        return 25'($urandom_range(0, 'h093FF));
    endfunction

    task automatic model_accept(input logic [24:0] a, input logic [7:0] d, input string tag);
        bit exp_acc;
        exp_acc = model_loading && (ref_region(a) != 6'b000000);
        check_val({tag, "_dn_wr"}, dn_wr, exp_acc);
        check_val({tag, "_rgn_sel"}, rgn_sel, exp_acc ? ref_region(a) : 6'b000000);
        if (exp_acc) begin
            check_val({tag, "_dn_addr"}, dn_addr, a[16:0]);
            check_val({tag, "_dn_data"}, dn_data, d);
            model_count++;
            model_sum = (model_sum + int'(d)) % 65536;
        end else if (model_loading) begin
            model_ovf = 1'b1;
        end
    endtask

    task automatic do_write(input logic [24:0] a, input logic [7:0] d, input int hold);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        cyc();
        model_accept(a, d, "wr");
        for (int k = 1; k < hold; k++) begin
            cyc();
            check_val("dn_wr_held", dn_wr, 1'b0);
        end
        ioctl_wr = 1'b0;
        cyc();
        check_val("dn_wr_gap", dn_wr, 1'b0);
        check_val("byte_count", byte_count, model_count);
        check_val("checksum", checksum, model_sum);
    endtask

    task automatic start_download();
        ioctl_download = 1'b1;
        cyc();
        model_loading = 1'b1;
        model_count   = 0;
        model_sum     = 0;
        model_ovf     = 1'b0;
        check_val("load_core_reset", core_reset, 1'b1);
        check_val("load_done_clr", load_done, 1'b0);
        check_val("load_err_clr", load_err, 1'b0);
        check_val("load_count_clr", byte_count, 17'd0);
        check_val("load_sum_clr", checksum, 16'd0);
    endtask

    task automatic end_download(input bit with_write, input logic [24:0] a, input logic [7:0] d);
        bit good;
        ioctl_download = 1'b0;
        if (with_write) begin
            ioctl_addr = a;
            ioctl_dout = d;
            ioctl_wr   = 1'b1;
        end
        cyc();
        if (with_write) begin
            model_accept(a, d, "fall_wr");
        end
        model_loading = 1'b0;
        ioctl_wr = 1'b0;
        good = (model_count == N) && !model_ovf;
        check_val("end_load_err", load_err, !good);
        check_val("end_core_reset", core_reset, 1'b1);
        check_val("end_load_done", load_done, 1'b0);
        check_val("end_count", byte_count, model_count);
        check_val("end_sum", checksum, model_sum);
        if (good) begin
            for (int k = 1; k < HOLD; k++) begin
                cyc();
                check_val("hold_core_reset", core_reset, 1'b1);
            end
            check_val("hold_load_done", load_done, 1'b0);
            cyc();
            check_val("run_core_reset", core_reset, 1'b0);
            check_val("run_load_done", load_done, 1'b1);
            check_val("run_load_err", load_err, 1'b0);
        end else begin
            repeat (HOLD + 4) cyc();
            check_val("err_core_reset", core_reset, 1'b1);
            check_val("err_load_done", load_done, 1'b0);
            check_val("err_load_err", load_err, 1'b1);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_dn_wr"}, dn_wr, 1'b0);
        check_val({tag, "_dn_addr"}, dn_addr, 17'd0);
        check_val({tag, "_dn_data"}, dn_data, 8'd0);
        check_val({tag, "_rgn_sel"}, rgn_sel, 6'b000000);
        check_val({tag, "_core_reset"}, core_reset, 1'b1);
        check_val({tag, "_load_done"}, load_done, 1'b0);
        check_val({tag, "_load_err"}, load_err, 1'b0);
        check_val({tag, "_checksum"}, checksum, 16'd0);
        check_val({tag, "_byte_count"}, byte_count, 17'd0);
    endtask

    initial begin
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = 25'd0;
        ioctl_dout     = 8'd0;
        model_loading  = 1'b0;
        model_count    = 0;
        model_sum      = 0;
        model_ovf      = 1'b0;
        cyc();
        cyc();
        check_reset_vals("rst");
        reset_n = 1'b1;
        cyc();

        // idle: strobes without a download are ignored
        do_write(25'h00100, 8'hAA, 1);
        check_val("idle_core_reset", core_reset, 1'b1);

        // exact load of 0x01 bytes spread across every region
        start_download();
        for (int i = 0; i < N; i++) do_write(25'(i * 394), 8'h01, 1);
        end_download(1'b0, 25'd0, 8'd0);
        check_val("exact_sum", checksum, 16'(N));

        // strobes while running are ignored
        do_write(25'h00200, 8'h55, 2);
        check_val("run_count_kept", byte_count, 17'(N));

        // reload from RUN: held strobe, region decode, last write on the fall
        start_download();
        do_write(25'h04000, 8'($urandom), 3);
        do_write(25'h08FFF, 8'($urandom), 1);
        for (int i = 0; i < N - 3; i++) do_write(rand_addr(), 8'($urandom), int'($urandom_range(1, 3)));
        end_download(1'b1, rand_addr(), 8'($urandom));

        // short load
        start_download();
        for (int i = 0; i < N - 1; i++) do_write(rand_addr(), 8'($urandom), int'($urandom_range(1, 2)));
        end_download(1'b0, 25'd0, 8'd0);

        // full image plus a write just past the end
        start_download();
        for (int i = 0; i < N; i++) do_write(rand_addr(), 8'($urandom), 1);
        do_write(25'h09400, 8'($urandom), 1);
        end_download(1'b0, 25'd0, 8'd0);

        // full image plus a write with upper address bits set
        start_download();
        for (int i = 0; i < N; i++) do_write(rand_addr(), 8'($urandom), 1);
        do_write(25'h0020010, 8'($urandom), 1);
        end_download(1'b0, 25'd0, 8'd0);

        // long load
        start_download();
        for (int i = 0; i < N + 1; i++) do_write(rand_addr(), 8'($urandom), 1);
        end_download(1'b0, 25'd0, 8'd0);

        // reset in the middle of a load
        start_download();
        for (int i = 0; i < 10; i++) do_write(rand_addr(), 8'($urandom), 1);
        reset_n = 1'b0;
        cyc();
        check_reset_vals("midrst");
        ioctl_download = 1'b0;
        cyc();
        reset_n = 1'b1;
        model_loading = 1'b0;
        model_count   = 0;
        model_sum     = 0;
        cyc();
        do_write(rand_addr(), 8'($urandom), 1);
        check_val("postrst_core_reset", core_reset, 1'b1);
        check_val("postrst_load_done", load_done, 1'b0);

        // clean reload after reset
        start_download();
        for (int i = 0; i < N; i++) do_write(rand_addr(), 8'($urandom), int'($urandom_range(1, 3)));
        end_download(1'b0, 25'd0, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter LOAD_BYTES, default 37888 (0x9400): exact byte count of a valid ROM image.
REQ-002 Parameter HOLD_CYCLES, default 16: clk_sys cycles core_reset stays asserted after a good load.
REQ-003 Clocking: one clock, clk_sys; reset is synchronous and active-low, named reset_n.
REQ-004 clk_sys  in  1  system clock; all logic on the rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 ioctl_download  in  1  high for the whole HPS download session.
REQ-007 ioctl_wr  in  1  byte strobe; may be held high for more than one cycle.
REQ-008 ioctl_addr  in  25  byte address within the image.
REQ-009 ioctl_dout  in  8  byte data.
REQ-010 dn_addr  out  17  core ROM write address (ioctl_addr[16:0], registered).
REQ-011 dn_data  out  8  core ROM write data (registered).
REQ-012 dn_wr  out  1  one-cycle write pulse to the core.
REQ-013 rgn_sel  out  6  one-hot target region for the current dn_wr; zero when dn_wr is low.
REQ-014 core_reset  out  1  active-high reset to the game core.
REQ-015 load_done  out  1  a valid image is loaded and the core is running.
REQ-016 load_err  out  1  the last download was short, long, or out of range.
REQ-017 checksum  out  16  modulo-2^16 sum of the accepted bytes of the last download.
REQ-018 byte_count  out  17  count of accepted bytes; saturates at 0x1FFFF.

Function
REQ-019 Region map (ioctl_addr), bit i of rgn_sel:
- bit 0: CPU1 ROM, 0x00000-0x03FFF
- bit 1: CPU2 ROM, 0x04000-0x04FFF
- bit 2: CPU3 ROM, 0x05000-0x05FFF
- bit 3: tile gfx, 0x06000-0x06FFF
- bit 4: sprite gfx, 0x07000-0x08FFF
- bit 5: PROMs, 0x09000-0x093FF
REQ-020 Write detection: a write event is the rising edge of ioctl_wr while ioctl_download is high; a held-high strobe yields exactly one event.
REQ-021 In-range write event:
- dn_wr pulses for one cycle, one cycle after the event
- dn_addr, dn_data and rgn_sel are valid in that same cycle
- byte_count increments; checksum adds the byte
REQ-022 Out-of-range write event (address >= 0x09400 or ioctl_addr[24:17] nonzero): no dn_wr pulse, no count, and an internal overflow flag is set.
REQ-023 FSM states: IDLE, LOAD, HOLD, RUN, ERR.
REQ-024 IDLE: core_reset=1. Rising edge of ioctl_download -> LOAD.
REQ-025 On every entry to LOAD:
- clear byte_count, checksum and the overflow flag
- clear load_done and load_err
- set core_reset=1
REQ-026 LOAD exit on the falling edge of ioctl_download:
- -> HOLD if byte_count==LOAD_BYTES and overflow flag is clear
- -> ERR otherwise
REQ-027 Same-cycle write and fall: a write event in the same cycle as the download falling edge is accepted and counted before the exit decision.
REQ-028 HOLD: core_reset=1 for exactly HOLD_CYCLES cycles, then -> RUN.
REQ-029 RUN: core_reset=0, load_done=1. Rising edge of ioctl_download -> LOAD (reload).
REQ-030 ERR: core_reset=1, load_err=1. Rising edge of ioctl_download -> LOAD.
REQ-031 Writes outside LOAD are ignored: no dn_wr, no count change.
REQ-032 Duplicate addresses are counted again; no address tracking.

Reset
REQ-033 While reset_n=0, on the clock edge:
- state=IDLE
- dn_wr=0, dn_addr=0, dn_data=0, rgn_sel=0
- core_reset=1, load_done=0, load_err=0
- checksum=0, byte_count=0, overflow flag cleared, edge detectors cleared
REQ-034 Reset mid-LOAD aborts the load; a fresh download rising edge is then required.

Structure
REQ-035 Region base/limit constants, the region index enumeration and the FSM state typedef go in the shared galaga_pkg package.
REQ-036 One sub-module, rom_region_decode: combinational address to one-hot rgn_sel plus an in_range flag.

Verification
REQ-037 Exact load: download 37888 bytes of value 0x01 at 0x00000-0x093FF -> 37888 dn_wr pulses, checksum=0x9400, then core_reset low exactly 16 cycles after the download falls, load_done=1.
REQ-038 Short load: 37887 bytes -> ERR, load_err=1, core_reset stays 1, load_done=0.
REQ-039 Out of range: a full image plus one write at 0x09400 -> that write gives no dn_wr, result ERR.
REQ-040 Held strobe and region decode: ioctl_wr held high 3 cycles at 0x04000 -> one dn_wr with rgn_sel=6'b000010; byte at 0x08FFF -> rgn_sel=6'b010000.
REQ-041 Edge case: last write coincides with the download falling edge -> byte counted, HOLD entered.
REQ-042 Reset and reload:
- reset_n low mid-load -> all outputs at reset values, IDLE
- a reload from RUN reasserts core_reset in the cycle after the download rising edge
